// File: rtl/cnn_conv1_mac_seq_if.sv
// Bus bundle for the conv1 MAC sequencer: block handshake, the two BRAM read
// ports and the link to the shared multiplier.
// The master side is the environment: loop control, BRAMs and multiplier.
// The slave side is the sequencer itself.
interface cnn_conv1_mac_seq_if #(
    parameter int DIN0_W = 10,
    parameter int DIN1_W = 14,
    parameter int PROD_W = 25,
    parameter int ACC_W  = 29,
    parameter int NTAPS  = 9,
    parameter int ADDR_W = $clog2(NTAPS)
);
    logic                     ap_start;
    logic                     ap_done;
    logic                     ap_idle;
    logic                     ap_ready;
    logic signed [ACC_W-1:0]  bias;
    logic [ADDR_W-1:0]        pix_addr;
    logic                     pix_ce;
    logic signed [DIN0_W-1:0] pix_q;
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_ce;
    logic signed [DIN1_W-1:0] w_q;
    logic signed [DIN0_W-1:0] mul_a;
    logic signed [DIN1_W-1:0] mul_b;
    logic signed [PROD_W-1:0] mul_p;
    logic signed [ACC_W-1:0]  res;

    modport master (
        output ap_start, bias, pix_q, w_q, mul_p,
        input  ap_done, ap_idle, ap_ready, pix_addr, pix_ce, w_addr, w_ce,
               mul_a, mul_b, res
    );

    modport slave (
        input  ap_start, bias, pix_q, w_q, mul_p,
        output ap_done, ap_idle, ap_ready, pix_addr, pix_ce, w_addr, w_ce,
               mul_a, mul_b, res
    );
endinterface

// File: rtl/cnn_conv1_mac_seq.sv
// conv1 3x3 window MAC sequencer: streams NTAPS pixel/weight pairs from two
// 1-cycle BRAM ports through one shared combinational multiplier, accumulates
// onto the bias and optionally applies ReLU. Pipeline: issue -> mult -> acc.
module cnn_conv1_mac_seq #(
    parameter int DIN0_W = 10,
    parameter int DIN1_W = 14,
    parameter int PROD_W = 25,
    parameter int ACC_W  = 29,
    parameter int NTAPS  = 9,
    parameter int RELU   = 1,
    parameter int ADDR_W = $clog2(NTAPS)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    cnn_conv1_mac_seq_if.slave     bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        addr_q;
    // [0] issue (BRAM read in flight), [1] mult, [2] accumulate
    logic [2:0]               vld_pipe_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  res_q;
    logic signed [ACC_W-1:0]  res_d;
    logic                     done_q;
    logic                     idle_q;

    assign bus.ap_done  = done_q;
    assign bus.ap_ready = done_q;
    assign bus.ap_idle  = idle_q;
    assign bus.pix_ce   = vld_pipe_q[0];
    assign bus.w_ce     = vld_pipe_q[0];
    assign bus.pix_addr = addr_q;
    assign bus.w_addr   = addr_q;
    assign bus.res      = res_q;

    // Multiplier operands: BRAM data passes through only while the mult stage is valid.
    always_comb begin
        bus.mul_a = '0;
        bus.mul_b = '0;
        if (vld_pipe_q[1]) begin
            bus.mul_a = bus.pix_q;
            bus.mul_b = bus.w_q;
        end
    end

    // Accumulator next value and the clamped result taken from it on the final add.
    always_comb begin
        acc_d = acc_q;
        if (vld_pipe_q[2])
            acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        res_d = acc_d;
        if (RELU != 0 && acc_d[ACC_W-1])
            res_d = '0;
    end

    // Control FSM plus datapath registers; DONE is entered on the edge that
    // retires the last product, so res and ap_done appear together.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            vld_pipe_q <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            vld_pipe_q[2:1] <= vld_pipe_q[1:0];
            prod_q          <= vld_pipe_q[1] ? bus.mul_p : '0;
            acc_q           <= acc_d;
            done_q          <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ap_start) begin
                        state_q       <= RUN;
                        idle_q        <= 1'b0;
                        acc_q         <= bus.bias;
                        addr_q        <= '0;
                        vld_pipe_q[0] <= 1'b1;
                    end
                end
                RUN: begin
                    if (addr_q == LAST) begin
                        state_q       <= DRAIN;
                        addr_q        <= '0;
                        vld_pipe_q[0] <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Only the accumulate stage is left: it retires on this edge.
                    if (vld_pipe_q[1:0] == 2'b00) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        res_q   <= res_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
